// File: rtl/idu_stage.sv
// Instruction decode stage: DEPTH-entry {pc,inst} queue feeding a registered RV32/RV64 decoder.
// Push at edge E0 gives out_valid after E1; in_ready tracks queue space only, out_* hold while out_ready=0.
module idu_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int HAS_M = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_funct3,
  output logic                     out_alt,
  output logic [8:0]               out_class,
  output logic                     out_is_word,
  output logic                     out_is_muldiv,
  output logic                     out_need_imm,
  output logic                     out_reg_wen,
  output logic [3:0]               out_wdt,
  output logic                     out_unsigned,
  output logic [2:0]               out_sys_op,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            alt;
    logic [8:0]      cls;
    logic            is_word;
    logic            is_muldiv;
    logic            need_imm;
    logic            reg_wen;
    logic [3:0]      wdt;
    logic            uns;
    logic [2:0]      sys_op;
    logic            illegal;
  } dec_t;

  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            out_vld_q;
  dec_t            out_q, dec;
  logic            push, pop;

  logic [31:0] hi;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic is_load, is_opimm, is_auipc, is_opimm32, is_store, is_op, is_lui, is_op32;
  logic is_branch, is_jalr, is_jal, is_system, known, bad;

  assign in_ready = (cnt != CW'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign pop      = (cnt != '0) & (~out_vld_q | out_ready) & ~flush;

  assign hi  = inst_mem[rd_ptr];
  assign opc = hi[6:0];
  assign f3  = hi[14:12];
  assign f7  = hi[31:25];

  assign is_load    = (opc == 7'b0000011);
  assign is_opimm   = (opc == 7'b0010011);
  assign is_auipc   = (opc == 7'b0010111);
  assign is_opimm32 = (opc == 7'b0011011);
  assign is_store   = (opc == 7'b0100011);
  assign is_op      = (opc == 7'b0110011);
  assign is_lui     = (opc == 7'b0110111);
  assign is_op32    = (opc == 7'b0111011);
  assign is_branch  = (opc == 7'b1100011);
  assign is_jalr    = (opc == 7'b1100111);
  assign is_jal     = (opc == 7'b1101111);
  assign is_system  = (opc == 7'b1110011);
  assign known = is_load | is_opimm | is_auipc | is_opimm32 | is_store | is_op | is_lui |
                 is_op32 | is_branch | is_jalr | is_jal | is_system;

  always_comb begin
    bad = (hi[1:0] != 2'b11) || (hi == 32'h0) || !known;
    if (is_op) begin
      if (f7 == 7'b0000001) begin
        if (HAS_M == 0) bad = 1'b1;
      end else if (f7 == 7'b0100000) begin
        if (f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
      end else if (f7 != 7'b0000000) bad = 1'b1;
    end
    if (is_op32) begin
      if (XLEN == 32) bad = 1'b1;
      if (f7 == 7'b0000001) begin
        if (HAS_M == 0 || f3 inside {3'b001, 3'b010, 3'b011}) bad = 1'b1;
      end else if (f7 == 7'b0100000) begin
        if (f3 != 3'b000 && f3 != 3'b101) bad = 1'b1;
      end else if (f7 == 7'b0000000) begin
        if (!(f3 inside {3'b000, 3'b001, 3'b101})) bad = 1'b1;
      end else bad = 1'b1;
    end
    // slli needs a clear upper field; srai may carry the arithmetic bit
    if (is_opimm && f3[1:0] == 2'b01) begin
      if (hi[31:26] != 6'b000000 && !(f3 == 3'b101 && hi[31:26] == 6'b010000)) bad = 1'b1;
      if (XLEN == 32 && hi[25]) bad = 1'b1;
    end
    if (is_opimm32) begin
      if (XLEN == 32) bad = 1'b1;
      case (f3)
        3'b000:  ;
        3'b001:  if (f7 != 7'b0000000) bad = 1'b1;
        3'b101:  if (f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1'b1;
        default: bad = 1'b1;
      endcase
    end
    if (is_load) begin
      if (f3 == 3'b111) bad = 1'b1;
      if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)) bad = 1'b1;
    end
    if (is_store && (f3[2] || (XLEN == 32 && f3 == 3'b011))) bad = 1'b1;
    if (is_branch && f3[2:1] == 2'b01) bad = 1'b1;
    if (is_system) begin
      if (f3 == 3'b100) bad = 1'b1;
      if (f3 == 3'b000 && hi != 32'h00000073 && hi != 32'h00100073 && hi != 32'h30200073)
        bad = 1'b1;
    end
  end

  always_comb begin
    dec        = '0;
    dec.pc     = pc_mem[rd_ptr];
    dec.rd     = hi[11:7];
    dec.rs1    = hi[19:15];
    dec.rs2    = hi[24:20];
    dec.funct3 = f3;
    dec.alt    = hi[30];
    dec.uns    = is_load & f3[2];
    dec.illegal = bad;
    if (is_lui || is_auipc)        dec.imm = XLEN'($signed({hi[31:12], 12'b0}));
    else if (is_jal)               dec.imm = XLEN'($signed({hi[31], hi[19:12], hi[20], hi[30:21], 1'b0}));
    else if (is_branch)            dec.imm = XLEN'($signed({hi[31], hi[7], hi[30:25], hi[11:8], 1'b0}));
    else if (is_store)             dec.imm = XLEN'($signed({hi[31:25], hi[11:7]}));
    else if (is_system && f3[2])   dec.imm = XLEN'(hi[19:15]);
    else if (is_op || is_op32)     dec.imm = '0;
    else                           dec.imm = XLEN'($signed(hi[31:20]));
    dec.need_imm = is_opimm | is_opimm32 | is_lui | is_auipc | is_jal | is_jalr | is_load | is_store;
    if (!bad) begin
      dec.cls       = {is_store, is_load, is_branch, is_jalr, is_jal, is_auipc, is_lui, is_op, is_opimm};
      dec.is_word   = is_opimm32 | is_op32;
      dec.is_muldiv = (is_op | is_op32) & (f7 == 7'b0000001);
      dec.reg_wen   = is_opimm | is_op | is_opimm32 | is_op32 | is_lui | is_auipc | is_jal |
                      is_jalr | is_load | (is_system & (f3 != 3'b000));
      dec.wdt       = (is_load | is_store) ? (4'b0001 << f3[1:0]) : 4'b0000;
      if (is_system) begin
        if (f3 != 3'b000)           dec.sys_op = 3'd4;
        else if (hi == 32'h00000073) dec.sys_op = 3'd1;
        else if (hi == 32'h00100073) dec.sys_op = 3'd2;
        else                         dec.sys_op = 3'd3;
      end
    end
  end

  // Queue storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (pop) begin
        out_q     <= dec;
        out_vld_q <= 1'b1;
      end else if (out_ready) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_valid     = out_vld_q;
  assign out_pc        = out_q.pc;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_imm       = out_q.imm;
  assign out_funct3    = out_q.funct3;
  assign out_alt       = out_q.alt;
  assign out_class     = out_q.cls;
  assign out_is_word   = out_q.is_word;
  assign out_is_muldiv = out_q.is_muldiv;
  assign out_need_imm  = out_q.need_imm;
  assign out_reg_wen   = out_q.reg_wen;
  assign out_wdt       = out_q.wdt;
  assign out_unsigned  = out_q.uns;
  assign out_sys_op    = out_q.sys_op;
  assign out_illegal   = out_q.illegal;
  assign count         = cnt;
endmodule
